// File: rtl/alu_host_driver.sv
// rtl/alu_host_driver.sv - host-side sequencer for the multi-cycle ALU start/sel/inbus/outbus/finish bus
// Optional macro ALU_HOST_TIMEOUT_EN: abort to a timeout response TIMEOUT cycles after start.
module alu_host_driver #(
  parameter int M_DELAY = 2,
  parameter int TIMEOUT = 64,
  parameter int TCW     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        alu_start,
  output logic [1:0]  alu_sel,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_finish,
  output logic        alu_clr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GAP, S_LOAD_M, S_WAIT_FIN, S_CAPT_LO, S_RESP, S_CLEAR
  } state_t;

  localparam logic [TCW-1:0] GAP_LAST = TCW'(M_DELAY - 1);

  state_t         state_q, state_d;
  logic [7:0]     b_q, b_d;
  logic [15:0]    result_q, result_d;
  logic [TCW-1:0] cnt_q, cnt_d, cnt_inc;
  logic           start_q, start_d;
  logic [1:0]     sel_q, sel_d;
  logic [7:0]     inbus_q, inbus_d;
  logic           clr_q, clr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_timeout_q, rsp_timeout_d;
  logic           timeout_hit;

`ifdef ALU_HOST_TIMEOUT_EN
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);
  // Decided one cycle early so the response appears exactly TIMEOUT cycles after START.
  assign timeout_hit = (cnt_q >= TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TCW'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  assign cnt_inc = (cnt_q == {TCW{1'b1}}) ? cnt_q : cnt_q + TCW'(1);

  always_comb begin
    state_d       = state_q;
    b_d           = b_q;
    result_d      = result_q;
    cnt_d         = cnt_q;
    start_d       = start_q;
    sel_d         = sel_q;
    inbus_d       = inbus_q;
    clr_d         = clr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          b_d      = req_b;
          sel_d    = req_op;
          inbus_d  = req_a;
          start_d  = 1'b1;
          cnt_d    = '0;
          result_d = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        start_d = 1'b0;
        cnt_d   = cnt_inc;
        if (M_DELAY > 1) begin
          state_d = S_GAP;
        end else begin
          inbus_d = b_q;
          state_d = S_LOAD_M;
        end
      end
      S_GAP: begin
        cnt_d = cnt_inc;
        if (cnt_q == GAP_LAST) begin
          inbus_d = b_q;
          state_d = S_LOAD_M;
        end
      end
      S_LOAD_M, S_WAIT_FIN: begin
        cnt_d = cnt_inc;
        if (alu_finish) begin
          // Two-byte results (mul/div) present the high byte first.
          if (sel_q[1]) begin
            result_d[15:8] = alu_outbus;
            state_d        = S_CAPT_LO;
          end else begin
            result_d    = {8'h00, alu_outbus};
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end else if (timeout_hit) begin
          result_d      = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else begin
          state_d = S_WAIT_FIN;
        end
      end
      S_CAPT_LO: begin
        result_d[7:0] = alu_outbus;
        rsp_valid_d   = 1'b1;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          clr_d         = 1'b1;
          sel_d         = 2'b00;
          inbus_d       = 8'h00;
          state_d       = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      b_q           <= '0;
      result_q      <= '0;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      sel_q         <= 2'b00;
      inbus_q       <= 8'h00;
      clr_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      b_q           <= b_d;
      result_q      <= result_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      sel_q         <= sel_d;
      inbus_q       <= inbus_d;
      clr_q         <= clr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign alu_start   = start_q;
  assign alu_sel     = sel_q;
  assign alu_inbus   = inbus_q;
  assign alu_clr     = clr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = result_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
